// File: rtl/binary_window_pkg.sv
// rtl/binary_window_pkg.sv - shared types and constants for the binary window filter
package binary_window_pkg;

  typedef enum logic [1:0] {MODE_MAJ, MODE_ERODE, MODE_DILATE, MODE_THRESH} mode_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam int EDGE_CONST     = 0;
  localparam int EDGE_REPLICATE = 1;

  function automatic int window_taps(input int radius);
    return (2 * radius + 1) * (2 * radius + 1);
  endfunction

endpackage

// File: rtl/bw_tag_pipe.sv
// rtl/bw_tag_pipe.sv - fixed-depth shift register carrying read tags alongside source reads
module bw_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o
);

  logic [TAG_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/binary_window_filter.sv
// rtl/binary_window_filter.sv - KxK binary window filter: tap address generator, accumulator, FSM
module binary_window_filter
  import binary_window_pkg::*;
#(
  parameter int WIDTH        = 480,
  parameter int HEIGHT       = 480,
  parameter int RADIUS       = 1,
  parameter int READ_LATENCY = 2,
  parameter int EDGE_MODE    = EDGE_CONST,
  parameter int EDGE_VALUE   = 0,
  localparam int K      = 2 * RADIUS + 1,
  localparam int KK     = window_taps(RADIUS),
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT),
  localparam int CNT_W  = $clog2(KK + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [1:0]        mode_in,
  input  logic [CNT_W-1:0]  thresh_in,
  output logic [ADDR_W-1:0] src_addr_out,
  input  logic              src_data_in,
  output logic [ADDR_W-1:0] dst_addr_out,
  output logic              dst_data_out,
  output logic              dst_valid_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int XW    = $clog2(WIDTH + 1);
  localparam int YW    = $clog2(HEIGHT + 1);
  localparam int TW    = $clog2(K + 1);
  // Signed tap coordinates need room for -R and (size-1)+R without wrapping.
  localparam int CW    = $clog2(WIDTH + 2 * RADIUS + 1) + 1;
  localparam int CH    = $clog2(HEIGHT + 2 * RADIUS + 1) + 1;
  localparam int TAG_W = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_e state_q, state_d;
  mode_e  mode_q;
  logic [CNT_W-1:0]  thresh_q;
  logic [XW-1:0]     px_q;
  logic [YW-1:0]     py_q;
  logic [TW-1:0]     tx_q, ty_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [ADDR_W-1:0] src_addr_q;
  logic [TAG_W-1:0]  iss_tag_q, ret_tag;
  logic [CNT_W-1:0]  ones_q, ones_sum;
  logic [ADDR_W-1:0] dst_addr_q;
  logic              dst_data_q, dst_valid_q;

  logic signed [CW-1:0] tap_x;
  logic signed [CH-1:0] tap_y;
  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;
  logic              x_oob, y_oob;
  logic [ADDR_W-1:0] tap_addr;
  logic              last_tap, last_pixel;
  logic              ret_valid, ret_oob, ret_last, tap_bit, decide;
  logic [ADDR_W-1:0] ret_addr;

  assign tap_x = $signed(CW'(px_q)) + $signed(CW'(tx_q)) - $signed(CW'(RADIUS));
  assign tap_y = $signed(CH'(py_q)) + $signed(CH'(ty_q)) - $signed(CH'(RADIUS));

  always_comb begin
    x_oob = 1'b0;
    cx    = XW'(tap_x);
    if (tap_x[CW-1]) begin
      x_oob = 1'b1;
      cx    = '0;
    end else if (tap_x > $signed(CW'(WIDTH - 1))) begin
      x_oob = 1'b1;
      cx    = XW'(WIDTH - 1);
    end
  end

  always_comb begin
    y_oob = 1'b0;
    cy    = YW'(tap_y);
    if (tap_y[CH-1]) begin
      y_oob = 1'b1;
      cy    = '0;
    end else if (tap_y > $signed(CH'(HEIGHT - 1))) begin
      y_oob = 1'b1;
      cy    = YW'(HEIGHT - 1);
    end
  end

  assign tap_addr   = ADDR_W'(cy) * ADDR_W'(WIDTH) + ADDR_W'(cx);
  assign last_tap   = (tx_q == TW'(K - 1)) && (ty_q == TW'(K - 1));
  assign last_pixel = (px_q == XW'(WIDTH - 1)) && (py_q == YW'(HEIGHT - 1));

  // Address generator: one tap per cycle, raster over pixels, row-major over taps.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q     <= MODE_MAJ;
      thresh_q   <= '0;
      px_q       <= '0;
      py_q       <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      pix_addr_q <= '0;
      src_addr_q <= '0;
      iss_tag_q  <= '0;
    end else begin
      iss_tag_q <= '0;
      if (state_q == IDLE && start_in) begin
        mode_q     <= mode_e'(mode_in);
        thresh_q   <= thresh_in;
        px_q       <= '0;
        py_q       <= '0;
        tx_q       <= '0;
        ty_q       <= '0;
        pix_addr_q <= '0;
      end else if (state_q == ISSUE) begin
        src_addr_q <= tap_addr;
        iss_tag_q  <= {1'b1, x_oob | y_oob, last_tap, pix_addr_q};
        if (tx_q == TW'(K - 1)) begin
          tx_q <= '0;
          if (ty_q == TW'(K - 1)) begin
            ty_q       <= '0;
            pix_addr_q <= pix_addr_q + ADDR_W'(1);
            if (px_q == XW'(WIDTH - 1)) begin
              px_q <= '0;
              py_q <= last_pixel ? '0 : py_q + YW'(1);
            end else begin
              px_q <= px_q + XW'(1);
            end
          end else begin
            ty_q <= ty_q + TW'(1);
          end
        end else begin
          tx_q <= tx_q + TW'(1);
        end
      end
    end
  end

  bw_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .tag_i  (iss_tag_q),
    .tag_o  (ret_tag)
  );

  assign ret_valid = ret_tag[ADDR_W+2];
  assign ret_oob   = ret_tag[ADDR_W+1];
  assign ret_last  = ret_tag[ADDR_W];
  assign ret_addr  = ret_tag[ADDR_W-1:0];

  assign tap_bit  = (EDGE_MODE == EDGE_CONST && ret_oob) ? 1'(EDGE_VALUE) : src_data_in;
  assign ones_sum = ones_q + CNT_W'(tap_bit);

  always_comb begin
    decide = 1'b0;
    case (mode_q)
      MODE_MAJ:    decide = ones_sum > CNT_W'(KK / 2);
      MODE_ERODE:  decide = ones_sum == CNT_W'(KK);
      MODE_DILATE: decide = ones_sum != '0;
      default:     decide = ones_sum >= thresh_q;
    endcase
  end

  // ones_q is cleared after each pixel's last tap, so it restarts at the next first tap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ones_q      <= '0;
      dst_addr_q  <= '0;
      dst_data_q  <= 1'b0;
      dst_valid_q <= 1'b0;
    end else begin
      dst_valid_q <= 1'b0;
      if (ret_valid) begin
        if (ret_last) begin
          ones_q      <= '0;
          dst_addr_q  <= ret_addr;
          dst_data_q  <= decide;
          dst_valid_q <= 1'b1;
        end else begin
          ones_q <= ones_sum;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = ISSUE;
      ISSUE:   if (last_tap && last_pixel) state_d = DRAIN;
      DRAIN:   if (dst_valid_q && dst_addr_q == LAST_ADDR) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state_q == ISSUE) || (state_q == DRAIN);
    done_out = (state_q == DONE);
  end

  assign src_addr_out  = src_addr_q;
  assign dst_addr_out  = dst_addr_q;
  assign dst_data_out  = dst_data_q;
  assign dst_valid_out = dst_valid_q;

endmodule

// File: tb/tb_binary_window_filter.sv
// tb/tb_binary_window_filter.sv - scoreboard bench for binary_window_filter on 4x4 images
module tb_binary_window_filter;
  import binary_window_pkg::*;

  typedef struct {int addr; int data;} exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start [3];
  logic [1:0] mode;
  logic [3:0] thr4;
  logic [4:0] thr5;
  logic [3:0] sa [3];
  logic       sd [3];
  logic [3:0] da [3];
  logic       dd [3];
  logic       dv [3];
  logic       busy [3];
  logic       done [3];
  logic       img [16];
  logic       r0 [2];
  logic       r1 [2];
  logic       r2 [4];

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_str [3];
  int   n_done [3];
  int   n_ones [3];
  exp_t sbq [$];
  int   strobe_t [$];
  int   done_t [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary_window_filter #(.WIDTH(4), .HEIGHT(4), .RADIUS(1), .READ_LATENCY(2),
                         .EDGE_MODE(0), .EDGE_VALUE(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start[0]), .mode_in(mode), .thresh_in(thr4),
    .src_addr_out(sa[0]), .src_data_in(sd[0]), .dst_addr_out(da[0]), .dst_data_out(dd[0]),
    .dst_valid_out(dv[0]), .busy_out(busy[0]), .done_out(done[0]));

  binary_window_filter #(.WIDTH(4), .HEIGHT(4), .RADIUS(1), .READ_LATENCY(2),
                         .EDGE_MODE(1), .EDGE_VALUE(0)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start[1]), .mode_in(mode), .thresh_in(thr4),
    .src_addr_out(sa[1]), .src_data_in(sd[1]), .dst_addr_out(da[1]), .dst_data_out(dd[1]),
    .dst_valid_out(dv[1]), .busy_out(busy[1]), .done_out(done[1]));

  binary_window_filter #(.WIDTH(4), .HEIGHT(4), .RADIUS(2), .READ_LATENCY(4),
                         .EDGE_MODE(0), .EDGE_VALUE(1)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start[2]), .mode_in(mode), .thresh_in(thr5),
    .src_addr_out(sa[2]), .src_data_in(sd[2]), .dst_addr_out(da[2]), .dst_data_out(dd[2]),
    .dst_valid_out(dv[2]), .busy_out(busy[2]), .done_out(done[2]));

  // Source BRAM models: 2, 2 and 4 cycle read latency.
  always @(posedge clk) begin
    r0[0] <= img[sa[0]];
    r0[1] <= r0[0];
    r1[0] <= img[sa[1]];
    r1[1] <= r1[0];
    r2[0] <= img[sa[2]];
    for (int i = 1; i < 4; i++) r2[i] <= r2[i-1];
  end
  assign sd[0] = r0[1];
  assign sd[1] = r1[1];
  assign sd[2] = r2[3];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  function automatic int golden(input int x, input int y, input int d, input int m, input int th);
    int r, em, ev, ones, kk, xx, yy, cx, cy;
    bit o;
    r    = (d == 2) ? 2 : 1;
    em   = (d == 1) ? 1 : 0;
    ev   = (d == 2) ? 1 : 0;
    ones = 0;
    kk   = (2 * r + 1) * (2 * r + 1);
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        xx = x + dx;
        yy = y + dy;
        o  = (xx < 0) || (xx > 3) || (yy < 0) || (yy > 3);
        cx = (xx < 0) ? 0 : ((xx > 3) ? 3 : xx);
        cy = (yy < 0) ? 0 : ((yy > 3) ? 3 : yy);
        ones += (o && em == 0) ? ev : int'(img[cy * 4 + cx]);
      end
    end
    case (m)
      0:       return int'(ones > kk / 2);
      1:       return int'(ones == kk);
      2:       return int'(ones != 0);
      default: return int'(ones >= th);
    endcase
  endfunction

  task automatic set_img(input int kind);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        case (kind)
          0:       img[y * 4 + x] = (x == 1 && y == 1);
          1:       img[y * 4 + x] = 1'b1;
          2:       img[y * 4 + x] = ((x + y) % 2 == 0);
          default: img[y * 4 + x] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (dv[i]) begin
        n_str[i]++;
        if (dd[i]) n_ones[i]++;
        if (i == 0) strobe_t.push_back(cyc - t0);
        if (sbq.size() == 0) begin
          chk("extra_strobe", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("dst_addr", int'(da[i]), e.addr);
          chk("dst_data", int'(dd[i]), e.data);
        end
      end
      if (done[i]) begin
        n_done[i]++;
        if (i == 0) done_t.push_back(cyc - t0);
      end
    end
  end

  // Mode/threshold are scrambled right after start to show they are latched.
  task automatic start_frame(input int d, input int m, input int th);
    @(negedge clk);
    mode     = 2'(m);
    thr4     = 4'(th);
    thr5     = 5'(th);
    start[d] = 1'b1;
    t0       = cyc + 1;
    @(negedge clk);
    start[d] = 1'b0;
    mode     = 2'(m + 1);
    thr4     = ~thr4;
    thr5     = ~thr5;
  endtask

  task automatic clear_stats(input int d);
    n_str[d]  = 0;
    n_done[d] = 0;
    n_ones[d] = 0;
    strobe_t.delete();
    done_t.delete();
    sbq.delete();
  endtask

  task automatic run_frame(input int d, input int m, input int th, input int stray);
    clear_stats(d);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        sbq.push_back('{addr: y * 4 + x, data: golden(x, y, d, m, th)});
    start_frame(d, m, th);
    for (int w = 0; w < 4000 && n_done[d] == 0; w++) begin
      start[d] = (stray > 0 && cyc - t0 == stray - 1);
      if (d == 0 && cyc - t0 == 1) chk("busy_c1", int'(busy[0]), 1);
      if (d == 0 && cyc - t0 == 3) chk("src_addr_c3", int'(sa[0]), 1);
      @(negedge clk);
    end
    start[d] = 1'b0;
    chk("done_seen", int'(n_done[d] > 0), 1);
    repeat (10) @(negedge clk);
    chk("strobes", n_str[d], 16);
    chk("done_once", n_done[d], 1);
    chk("sb_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic run_reset_test();
    set_img(0);
    clear_stats(0);
    for (int p = 0; p < 7; p++)
      sbq.push_back('{addr: p, data: golden(p % 4, p / 4, 0, 2, 0)});
    start_frame(0, 2, 0);
    while (cyc - t0 < 70) @(negedge clk);
    chk("busy_pre_rst", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_src_addr", int'(sa[0]), 0);
    chk("rst_dst_valid", int'(dv[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("rst_strobes", n_str[0], 7);
    chk("rst_no_done", n_done[0], 0);
    chk("rst_sb_empty", sbq.size(), 0);
    run_frame(0, 2, 0, -1);
    chk("rst_refill_ones", n_ones[0], 9);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i]  = 1'b0;
      n_str[i]  = 0;
      n_done[i] = 0;
      n_ones[i] = 0;
    end
    mode = 2'd0;
    thr4 = '0;
    thr5 = '0;
    set_img(0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_dst_valid", int'(dv[0]), 0);
    chk("reset_src_addr", int'(sa[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy[0]), 0);

    run_frame(0, MODE_DILATE, 0, 50);
    chk("dilate_ones", n_ones[0], 9);
    chk("first_strobe", strobe_t.size() > 0 ? strobe_t[0] : -1, 12);
    for (int i = 1; i < strobe_t.size(); i++) chk("strobe_gap", strobe_t[i] - strobe_t[i-1], 9);
    chk("done_cycle", done_t.size() > 0 ? done_t[0] : -1, 148);

    set_img(1);
    run_frame(0, MODE_ERODE, 0, -1);
    chk("erode_const_ones", n_ones[0], 4);
    run_frame(1, MODE_ERODE, 0, -1);
    chk("erode_repl_ones", n_ones[1], 16);

    set_img(2);
    run_frame(0, MODE_MAJ, 0, -1);
    run_frame(0, MODE_THRESH, 9, -1);
    chk("thresh9_ones", n_ones[0], 0);
    run_frame(0, MODE_THRESH, 0, -1);
    chk("thresh0_ones", n_ones[0], 16);

    run_reset_test();

    set_img(3);
    run_frame(2, MODE_MAJ, 0, -1);
    run_frame(2, MODE_THRESH, $urandom_range(1, 24), -1);
    run_frame(2, MODE_DILATE, 0, -1);
    run_frame(2, MODE_ERODE, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
